stall_slot_arbiter: RTL and testbench

- Stall manager for N_LANES `buffer_slots` instances that share one downstream consumer port.
- Drives each lane's `stall` input so that at most one lane drains per cycle, chosen round-robin.
- Keeps a shadow occupancy count per lane, muxes the granted lane's `outputs` into a registered output stage, and flags slot overflow.

---
 rtl/stall_slot_arbiter_pkg.sv | 10 +
 rtl/stall_slot_arbiter_rr_pick.sv | 29 ++
 rtl/stall_slot_arbiter.sv | 107 ++++++++++
 tb/tb_stall_slot_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/stall_slot_arbiter_pkg.sv
// rtl/stall_slot_arbiter_pkg.sv - shared defaults and types for the stall slot arbiter
package stall_pkg;
  localparam int N_LANES_DEF = 4;
  localparam int DATA_W_DEF  = 32;
  localparam int DEPTH_DEF   = 8;

  localparam logic [31:0] EMPTY_WORD = 32'hFFFF_FFFF;

  typedef logic [$clog2(N_LANES_DEF)-1:0] lane_idx_t;
endpackage

// File: rtl/stall_slot_arbiter_rr_pick.sv
// rtl/stall_slot_arbiter_rr_pick.sv - combinational round-robin picker starting at i_ptr
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);
  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= N) w_j = w_j - N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = W'(w_j);
      end
    end
  end
endmodule

// File: rtl/stall_slot_arbiter.sv
// rtl/stall_slot_arbiter.sv - round-robin stall manager for lanes sharing one consumer port
module stall_slot_arbiter
  import stall_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LANE_W  = $clog2(N_LANES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_LANES-1:0]    lane_push,
  input  logic [N_LANES*DATA_W-1:0] lane_data,
  output logic [N_LANES-1:0]    lane_stall,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [LANE_W-1:0]     out_lane,
  output logic [N_LANES-1:0]    overflow_err,
  output logic [15:0]           fwd_count
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0]   r_cnt [N_LANES];
  logic [LANE_W-1:0]  r_rr_ptr;
  logic               r_gq_valid;
  logic [LANE_W-1:0]  r_gq_lane;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [LANE_W-1:0]  r_out_lane;
  logic [N_LANES-1:0] r_ovf;
  logic [15:0]        r_fwd_count;

  logic [N_LANES-1:0] w_req;
  logic [N_LANES-1:0] w_gnt;
  logic [LANE_W-1:0]  w_win;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_data;

  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_LANES; i++) w_req[i] = lane_push[i] | (r_cnt[i] != '0);
  end

  rr_pick #(.N(N_LANES), .W(LANE_W)) u_pick (
    .i_req (w_req & {N_LANES{out_ready}}),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win),
    .o_any (w_any)
  );

  // Lanes must stay frozen for as long as reset is held, independent of the clock.
  assign lane_stall = reset ? '1 : ~w_gnt;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < N_LANES; i++)
      if (r_gq_lane == LANE_W'(i)) w_sel_data = lane_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_LANES; i++) r_cnt[i] <= '0;
      r_ovf    <= '0;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (lane_push[i] && !w_gnt[i]) begin
          if (r_cnt[i] == CNT_W'(DEPTH)) r_ovf[i] <= 1'b1;
          else r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!lane_push[i] && w_gnt[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      if (w_any)
        r_rr_ptr <= (w_win == LANE_W'(N_LANES - 1)) ? '0 : w_win + 1'b1;
    end
  end

  // The granted lane presents its word one cycle after the grant, hence two stages.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gq_valid  <= 1'b0;
      r_gq_lane   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '1;
      r_out_lane  <= '0;
      r_fwd_count <= '0;
    end else begin
      r_gq_valid  <= w_any;
      r_gq_lane   <= w_win;
      r_out_valid <= r_gq_valid;
      if (r_gq_valid) begin
        r_out_data  <= w_sel_data;
        r_out_lane  <= r_gq_lane;
        r_fwd_count <= r_fwd_count + 16'd1;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_lane     = r_out_lane;
  assign overflow_err = r_ovf;
  assign fwd_count    = r_fwd_count;
endmodule

// File: tb/tb_stall_slot_arbiter.sv
// tb/tb_stall_slot_arbiter.sv - directed and random bench with FIFO-level lane model
module tb_stall_slot_arbiter;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  lane_push;
  logic [N*DW-1:0] lane_data;
  logic [N-1:0]  lane_stall;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_lane;
  logic [N-1:0]  overflow_err;
  logic [15:0]   fwd_count;

  always #5 clk = ~clk;

  stall_slot_arbiter #(.N_LANES(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .lane_push(lane_push), .lane_data(lane_data),
    .lane_stall(lane_stall), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_lane(out_lane), .overflow_err(overflow_err),
    .fwd_count(fwd_count)
  );

  int tests = 0;
  int fails = 0;

  // Each lane is modelled as a plain FIFO of the words it holds.
  logic [31:0] mem [N][DEPTH];
  int          hd [N];
  int          sz [N];
  int          rr;
  logic        bus_v;
  int          bus_l;
  logic [31:0] bus_w;
  logic        exp_v;
  logic [31:0] exp_d;
  int          exp_l;
  logic [15:0] exp_fwd;
  logic [N-1:0] exp_ovf;
  logic [31:0] pw [N];
  logic        fix_w = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin hd[i] = 0; sz[i] = 0; end
    rr = 0; bus_v = 1'b0; bus_l = 0; bus_w = '0;
    exp_v = 1'b0; exp_d = 32'hFFFF_FFFF; exp_l = 0; exp_fwd = '0; exp_ovf = '0;
  endtask

  task automatic step(input logic [N-1:0] push, input logic rdy);
    int g;
    int j;
    logic [N-1:0] st;
    logic [31:0] popped;
    popped = '0;
    for (int i = 0; i < N; i++) if (!fix_w) pw[i] = $urandom;
    lane_push = push;
    out_ready = rdy;
    for (int i = 0; i < N; i++) lane_data[i*DW +: DW] = $urandom;
    if (bus_v) lane_data[bus_l*DW +: DW] = bus_w;
    #1;
    g = -1;
    if (rdy)
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (g < 0 && (push[j] || sz[j] > 0)) g = j;
      end
    st = '1;
    if (g >= 0) st[g] = 1'b0;
    chk("lane_stall", 64'(lane_stall), 64'(st));
    for (int i = 0; i < N; i++) begin
      if (push[i]) begin
        if (i != g && sz[i] == DEPTH) exp_ovf[i] = 1'b1;
        else begin mem[i][(hd[i] + sz[i]) % DEPTH] = pw[i]; sz[i]++; end
      end
      if (i == g) begin
        popped = mem[i][hd[i]];
        hd[i] = (hd[i] + 1) % DEPTH;
        sz[i]--;
      end
    end
    if (g >= 0) rr = (g + 1) % N;
    @(posedge clk);
    #1;
    exp_v = bus_v;
    if (bus_v) begin exp_d = bus_w; exp_l = bus_l; exp_fwd = exp_fwd + 16'd1; end
    bus_v = (g >= 0);
    bus_l = (g >= 0) ? g : 0;
    bus_w = popped;
    chk("out_valid", 64'(out_valid), 64'(exp_v));
    chk("out_data", 64'(out_data), 64'(exp_d));
    if (exp_v) chk("out_lane", 64'(out_lane), 64'(exp_l));
    chk("fwd_count", 64'(fwd_count), 64'(exp_fwd));
    chk("overflow_err", 64'(overflow_err), 64'(exp_ovf));
    for (int i = 0; i < N; i++) chk("shadow_cnt", 64'(dut.r_cnt[i]), 64'(sz[i]));
  endtask

  initial begin
    model_reset();
    reset = 1'b1; lane_push = '0; out_ready = 1'b0; lane_data = '0;
    #12;
    chk("rst_stall", 64'(lane_stall), 64'hF);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", 64'(out_data), 64'hFFFF_FFFF);
    chk("rst_fwd", 64'(fwd_count), 64'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Single-lane pass-through.
    fix_w = 1'b1;
    pw[0] = 32'hA5A5_0001; pw[1] = 32'h1; pw[2] = 32'h2; pw[3] = 32'h3;
    step(4'b0001, 1'b1);
    fix_w = 1'b0;
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    chk("t1_data", 64'(out_data), 64'hA5A5_0001);
    chk("t1_fwd", 64'(fwd_count), 64'h1);

    // Four simultaneous pushes, then drain in order.
    step(4'b1111, 1'b1);
    repeat (5) step(4'b0000, 1'b1);

    // Hold off five lane-2 pushes, then release.
    repeat (5) step(4'b0100, 1'b0);
    repeat (8) step(4'b0000, 1'b1);

    // Overflow on lane 1.
    repeat (9) step(4'b0010, 1'b0);
    chk("t4_ovf", 64'(overflow_err), 64'h2);
    repeat (11) step(4'b0000, 1'b1);
    chk("t4_ovf_sticky", 64'(overflow_err), 64'h2);

    // Round-robin fairness between lanes 0 and 3.
    repeat (8) step(4'b1001, 1'b1);
    repeat (10) step(4'b0000, 1'b1);

    // Async reset while a word is on the output.
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    chk("t6_pre_valid", 64'(out_valid), 64'h1);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 64'(out_valid), 64'h0);
    chk("t6_stall", 64'(lane_stall), 64'hF);
    chk("t6_data", 64'(out_data), 64'hFFFF_FFFF);
    chk("t6_fwd", 64'(fwd_count), 64'h0);
    chk("t6_ovf", 64'(overflow_err), 64'h0);
    for (int i = 0; i < N; i++) chk("t6_cnt", 64'(dut.r_cnt[i]), 64'h0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Random traffic.
    for (int c = 0; c < 300; c++)
      step(4'($urandom & $urandom), ($urandom_range(0, 3) != 0));
    repeat (40) step(4'b0000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
